counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter xLen, default 64, meaning the data width of the count value and command payload.
REQ-002 SHALL have parameter WAIT_CYC, default 3, meaning the number of cycles between a counter command pulse and sampling ctr_current_count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: host command valid.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the controller accepts a command.
REQ-007 SHALL have port cmd_op, input, 2 bits: 00 INIT, 01 START, 10 READ, 11 STATUS.
REQ-008 SHALL have port cmd_data, input, xLen bits: the INIT payload.
REQ-009 SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the host accepts the response.
REQ-011 SHALL have port rsp_data, output, xLen bits: the response payload.
REQ-012 SHALL have port rsp_err, output, 1 bit: the command was rejected.
REQ-013 SHALL have ports ctr_init, ctr_start and ctr_return_current_count, each an output of 1 bit: single-cycle command pulses to the counter.
REQ-014 SHALL have port ctr_init_val, output, xLen bits: the init value, held stable while ctr_init is high.
REQ-015 SHALL have port ctr_current_count, input, xLen bits: the count value from the counter.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, RESP; cmd_ready=1 only in IDLE.
REQ-017 SHALL capture cmd_op and cmd_data into registers on handshake (cmd_valid & cmd_ready), then enter ISSUE.
REQ-018 ISSUE SHALL last exactly one cycle and assert exactly one pulse chosen by op: INIT -> ctr_init; START -> ctr_start; READ while running -> ctr_return_current_count; READ while not running, STATUS, or rejected -> no pulse.
REQ-019 WAIT SHALL count WAIT_CYC cycles after ISSUE for INIT and for running READ, sample ctr_current_count on the final cycle, then enter RESP; all other ops SHALL skip WAIT and go straight to RESP.
REQ-020 A running flag SHALL be set by an accepted START and never cleared except by reset.
REQ-021 INIT while running SHALL be rejected: no pulse, rsp_err=1, rsp_data=0.
REQ-022 START while running SHALL issue no pulse and give rsp_err=0; rsp_data SHALL be 0 for every START.
REQ-023 READ while not running SHALL return ctr_current_count, sampled in the ISSUE cycle, with rsp_err=0.
REQ-024 STATUS SHALL return rsp_data[0]=running, with rsp_data[xLen-1:1]=0 unless REQ-030 applies.
REQ-025 RESP SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready; the handshake SHALL return the block to IDLE.
REQ-026 Minimum command-to-rsp_valid latency SHALL be 2 cycles (ISSUE, RESP); waited ops SHALL take 2+WAIT_CYC cycles.
REQ-027 cmd_valid held through RESP SHALL NOT be accepted until the next IDLE cycle, with no back-to-back overlap.

Reset
REQ-028 On reset, the state SHALL be IDLE, running=0, and all outputs 0 (cmd_ready becomes 1 the cycle after reset deasserts); a mid-operation reset SHALL abandon the command with no response and no further pulses.

Configuration
REQ-029 Macro COUNTER_CTRL_STATS_EN SHALL compile in a 16-bit saturating accepted-command counter.
REQ-030 With COUNTER_CTRL_STATS_EN defined, STATUS SHALL return rsp_data[16:1]=command count (the STATUS command itself included); without the macro these bits SHALL read 0 and the counter SHALL be absent.

Structure
REQ-031 A shared package counter_ctrl_pkg SHALL hold the op encodings, the state enumeration and the STATUS bit positions.
REQ-032 The block SHALL be a single module; the WAIT counter is inline, with no sub-module.

Verification
REQ-033 Reset, then INIT 0x10 -> one ctr_init pulse with ctr_init_val=0x10; rsp after 5 cycles with data=0x10, err=0.
REQ-034 START, then READ with ctr_current_count driven to 0x2A -> one ctr_start pulse, one ctr_return_current_count pulse, rsp data=0x2A, err=0.
REQ-035 INIT after START -> no ctr_init pulse; rsp err=1, data=0.
REQ-036 STATUS with rsp_ready held low for 4 cycles -> rsp stable throughout, data[0]=1 when running, cmd_ready=0 until the handshake.
REQ-037 Reset asserted during WAIT of a READ -> no rsp_valid, running=0, next STATUS returns 0.
REQ-038 With COUNTER_CTRL_STATS_EN, 3 commands then STATUS -> rsp_data[16:1]=4.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter command controller: ops, FSM states
// and the bit layout of the STATUS response word.
package counter_ctrl_pkg;

  localparam logic [1:0] OP_INIT   = 2'b00;
  localparam logic [1:0] OP_START  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int STAT_RUN_BIT = 0;
  localparam int STAT_CNT_LSB = 1;
  localparam int STAT_CNT_W   = 16;

endpackage

// File: rtl/counter_ctrl.sv
// Command front end for an external counter: issues single-cycle pulses and
// returns one response per command. COUNTER_CTRL_STATS_EN adds a command counter.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int xLen     = 64,
  parameter int WAIT_CYC = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [xLen-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [xLen-1:0] rsp_data,
  output logic            rsp_err,
  output logic            ctr_init,
  output logic            ctr_start,
  output logic            ctr_return_current_count,
  output logic [xLen-1:0] ctr_init_val,
  input  logic [xLen-1:0] ctr_current_count
);

  localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  logic [1:0]      state;
  logic [1:0]      op_q;
  logic [xLen-1:0] data_q;
  logic            running;
  logic            armed;
  logic [WW-1:0]   wait_cnt;
  logic [xLen-1:0] status_word;
  logic            accept;
  logic            issue;

  // armed keeps cmd_ready low until the first clock after reset is released
  assign cmd_ready = (state == ST_IDLE) && armed;
  assign accept    = cmd_valid && cmd_ready;
  assign issue     = (state == ST_ISSUE);
  assign rsp_valid = (state == ST_RESP);

  assign ctr_init                 = issue && (op_q == OP_INIT)  && !running;
  assign ctr_start                = issue && (op_q == OP_START) && !running;
  assign ctr_return_current_count = issue && (op_q == OP_READ)  && running;
  assign ctr_init_val             = ctr_init ? data_q : '0;

`ifdef COUNTER_CTRL_STATS_EN
  logic [STAT_CNT_W-1:0] cmd_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_count <= '0;
    end else if (accept && (cmd_count != '1)) begin
      cmd_count <= cmd_count + 1'b1;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_RUN_BIT] = running;
    status_word[STAT_CNT_LSB +: STAT_CNT_W] = cmd_count;
  end
`else
  always_comb begin
    status_word = '0;
    status_word[STAT_RUN_BIT] = running;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_INIT;
      data_q   <= '0;
      running  <= 1'b0;
      armed    <= 1'b0;
      wait_cnt <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_err  <= 1'b0;
          rsp_data <= '0;
          state    <= ST_RESP;
          case (op_q)
            OP_INIT: begin
              if (running) begin
                rsp_err <= 1'b1;
              end else begin
                wait_cnt <= WW'(WAIT_CYC - 1);
                state    <= ST_WAIT;
              end
            end
            OP_START: running <= 1'b1;
            OP_READ: begin
              if (running) begin
                wait_cnt <= WW'(WAIT_CYC - 1);
                state    <= ST_WAIT;
              end else begin
                rsp_data <= ctr_current_count;
              end
            end
            default: rsp_data <= status_word;
          endcase
        end
        ST_WAIT: begin
          // the counter needs WAIT_CYC cycles to settle; sample on the last one
          if (wait_cnt == '0) begin
            rsp_data <= ctr_current_count;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          if (rsp_ready) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with a scoreboard of expected responses
// and a stub counter that loads on ctr_init. Honors COUNTER_CTRL_STATS_EN.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int XLEN     = 64;
  localparam int WAIT_CYC = 3;

  typedef struct {
    logic [XLEN-1:0] data;
    logic            err;
  } rsp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [XLEN-1:0] cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            ctr_init;
  logic            ctr_start;
  logic            ctr_return_current_count;
  logic [XLEN-1:0] ctr_init_val;
  logic [XLEN-1:0] ctr_current_count;
  logic            load_req;
  logic [XLEN-1:0] load_val;

  int tests_run = 0;
  int tests_failed = 0;
  int n_init = 0;
  int n_start = 0;
  int n_ret = 0;
  logic [XLEN-1:0] last_init_val = '0;

  rsp_t sb_q[$];
  bit              m_running;
  int              m_cmds;
  logic [XLEN-1:0] m_count;

  always #5 clk = ~clk;

  counter_ctrl #(.xLen(XLEN), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .ctr_init(ctr_init),
    .ctr_start(ctr_start),
    .ctr_return_current_count(ctr_return_current_count),
    .ctr_init_val(ctr_init_val),
    .ctr_current_count(ctr_current_count)
  );

  // Stub counter: takes the init value on ctr_init, or a value forced by the bench.
  always_ff @(posedge clk) begin
    if (ctr_init) ctr_current_count <= ctr_init_val;
    else if (load_req) ctr_current_count <= load_val;
  end

  always @(negedge clk) begin
    if (ctr_init) begin
      n_init++;
      last_init_val = ctr_init_val;
    end
    if (ctr_start) n_start++;
    if (ctr_return_current_count) n_ret++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [XLEN-1:0] status_model();
    logic [XLEN-1:0] w;
    w = '0;
    w[STAT_RUN_BIT] = m_running;
`ifdef COUNTER_CTRL_STATS_EN
    w[STAT_CNT_LSB +: STAT_CNT_W] = m_cmds[STAT_CNT_W-1:0];
`endif
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [XLEN-1:0] data);
    int cyc;
    @(negedge clk);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("cmd_accept", XLEN'(cmd_ready), XLEN'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    if (m_cmds < 65535) m_cmds++;
  endtask

  // Drives one command, models its result into the scoreboard, then checks
  // latency, pulses, hold stability and the popped response.
  task automatic applyStimulus(input logic [1:0] op, input logic [XLEN-1:0] data,
                               input int hold);
    rsp_t exp_rsp;
    rsp_t got;
    int exp_init, exp_start, exp_ret, exp_lat, lat;
    int pre_init, pre_start, pre_ret;
    logic [XLEN-1:0] hold_data;
    logic            hold_err;
    bit was_running;

    was_running = m_running;
    exp_init = 0; exp_start = 0; exp_ret = 0; exp_lat = 2;
    pre_init = n_init; pre_start = n_start; pre_ret = n_ret;
    send_cmd(op, data);
    exp_rsp.data = '0;
    exp_rsp.err  = 1'b0;
    case (op)
      OP_INIT: begin
        if (was_running) exp_rsp.err = 1'b1;
        else begin
          exp_rsp.data = data; exp_init = 1; exp_lat = 2 + WAIT_CYC; m_count = data;
        end
      end
      OP_START: begin
        exp_start = was_running ? 0 : 1;
        m_running = 1'b1;
      end
      OP_READ: begin
        exp_rsp.data = m_count;
        if (was_running) begin exp_ret = 1; exp_lat = 2 + WAIT_CYC; end
      end
      default: exp_rsp.data = status_model();
    endcase
    sb_q.push_back(exp_rsp);

    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", XLEN'(lat), XLEN'(exp_lat));
    hold_data = rsp_data;
    hold_err  = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", XLEN'(rsp_valid), XLEN'(1));
      checkOutput("hold_data", rsp_data, hold_data);
      checkOutput("hold_err", XLEN'(rsp_err), XLEN'(hold_err));
      checkOutput("hold_cmd_ready", XLEN'(cmd_ready), XLEN'(0));
    end
    rsp_ready = 1'b1;
    got = sb_q.pop_front();
    checkOutput("rsp_data", rsp_data, got.data);
    checkOutput("rsp_err", XLEN'(rsp_err), XLEN'(got.err));
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", XLEN'(rsp_valid), XLEN'(0));
    checkOutput("n_init", XLEN'(n_init - pre_init), XLEN'(exp_init));
    checkOutput("n_start", XLEN'(n_start - pre_start), XLEN'(exp_start));
    checkOutput("n_ret", XLEN'(n_ret - pre_ret), XLEN'(exp_ret));
  endtask

  initial begin
    int pre_ret;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_INIT;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    load_req  = 1'b1;
    load_val  = '0;
    m_running = 1'b0;
    m_cmds    = 0;
    m_count   = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", XLEN'(cmd_ready), XLEN'(0));
    checkOutput("reset_rsp_valid", XLEN'(rsp_valid), XLEN'(0));
    checkOutput("reset_rsp_data", rsp_data, '0);
    checkOutput("reset_pulses", XLEN'({ctr_init, ctr_start, ctr_return_current_count}), XLEN'(0));
    load_req = 1'b0;
    reset    = 1'b0;
    #1;
    checkOutput("ready_before_edge", XLEN'(cmd_ready), XLEN'(0));
    @(negedge clk);
    checkOutput("ready_after_reset", XLEN'(cmd_ready), XLEN'(1));

    applyStimulus(OP_INIT, 64'h10, 0);
    checkOutput("init_val", last_init_val, 64'h10);
    applyStimulus(OP_READ, '0, 0);
    applyStimulus(OP_START, '0, 0);

    @(negedge clk);
    load_req = 1'b1;
    load_val = 64'h2A;
    @(negedge clk);
    load_req = 1'b0;
    m_count  = 64'h2A;
    applyStimulus(OP_READ, '0, 0);
    applyStimulus(OP_INIT, 64'h55, 0);
    applyStimulus(OP_START, '0, 0);
    applyStimulus(OP_STATUS, '0, 4);

    // Reset lands in the WAIT phase of a running READ.
    pre_ret = n_ret;
    send_cmd(OP_READ, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("midreset_rsp_valid", XLEN'(rsp_valid), XLEN'(0));
    end
    reset     = 1'b0;
    m_running = 1'b0;
    m_cmds    = 0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_reset_rsp_valid", XLEN'(rsp_valid), XLEN'(0));
    end
    checkOutput("midreset_ret_pulses", XLEN'(n_ret - pre_ret), XLEN'(1));

    applyStimulus(OP_STATUS, '0, 0);
    applyStimulus(OP_INIT, 64'h7, 0);
    applyStimulus(OP_READ, '0, 0);
    applyStimulus(OP_STATUS, '0, 0);
`ifdef COUNTER_CTRL_STATS_EN
    checkOutput("stats_model", XLEN'(m_cmds), XLEN'(4));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
